// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs req/ack data-memory transactions for loads and
// stores, aligns and extends load data, and registers the result bundle for writeback.
module mem_access #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_to_reg,
  input  logic        i_reg_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_aluresult,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rd_addr,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  output logic        o_valid,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_aluresult,
  output logic [31:0] o_write_data,
  output logic [1:0]  o_exc
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          mem_op, illegal, misaligned, fault, start, done, timeout;
  logic [31:0]   cap_addr;
  logic [2:0]    cap_funct3;
  logic [4:0]    cap_rd;
  logic          cap_mem_to_reg, cap_reg_write, cap_we;

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return 4'b0011 << lane;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      3'b000:  return {4{data[7:0]}};
      3'b001:  return {2{data[15:0]}};
      3'b010:  return data;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return rdata;
      3'b100:  return {24'h00_0000, b};
      3'b101:  return {16'h0000, h};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Width legality and alignment of the presented access.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (i_funct3)
      3'b000:  misaligned = 1'b0;
      3'b001:  misaligned = i_aluresult[0];
      3'b010:  misaligned = (i_aluresult[1:0] != 2'b00);
      3'b100:  illegal    = i_mem_write;
      3'b101:  begin
        illegal    = i_mem_write;
        misaligned = i_aluresult[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign mem_op  = i_valid & (i_mem_read | i_mem_write);
  assign fault   = (state == IDLE) & mem_op & (illegal | misaligned);
  assign start   = (state == IDLE) & mem_op & ~(illegal | misaligned);
  assign done    = (state == REQ) & i_dmem_ack;
  assign timeout = (state == REQ) & ~i_dmem_ack & (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? REQ : IDLE;
      REQ:     next_state = (done || timeout) ? IDLE : REQ;
      default: next_state = IDLE;
    endcase
  end

  // Stall output; released on the terminating cycle (ack or timeout) so upstream advances once.
  always_comb begin
    o_stall = 1'b0;
    case (state)
      IDLE:    o_stall = start;
      REQ:     o_stall = ~(i_dmem_ack | timeout);
      default: o_stall = 1'b0;
    endcase
  end

  // Wait-cycle counter, cleared whenever not waiting in REQ.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                     cnt <= '0;
    else if ((state == REQ) && !done && !timeout) cnt <= cnt + CW'(1);
    else                                           cnt <= '0;
  end

  // Bus request and captured instruction, held stable for the whole transaction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dmem_req     <= 1'b0;
      o_dmem_we      <= 1'b0;
      o_dmem_addr    <= 32'h0000_0000;
      o_dmem_wdata   <= 32'h0000_0000;
      o_dmem_be      <= 4'b0000;
      cap_addr       <= 32'h0000_0000;
      cap_funct3     <= 3'b000;
      cap_rd         <= 5'd0;
      cap_mem_to_reg <= 1'b0;
      cap_reg_write  <= 1'b0;
      cap_we         <= 1'b0;
    end else if (start) begin
      o_dmem_req     <= 1'b1;
      o_dmem_we      <= i_mem_write;
      o_dmem_addr    <= {i_aluresult[31:2], 2'b00};
      o_dmem_wdata   <= i_mem_write ? store_wdata(i_funct3, i_store_data) : 32'h0000_0000;
      o_dmem_be      <= i_mem_write ? store_be(i_funct3, i_aluresult[1:0]) : 4'b0000;
      cap_addr       <= i_aluresult;
      cap_funct3     <= i_funct3;
      cap_rd         <= i_rd_addr;
      cap_mem_to_reg <= i_mem_to_reg;
      cap_reg_write  <= i_reg_write;
      cap_we         <= i_mem_write;
    end else if (done || timeout) begin
      o_dmem_req <= 1'b0;
      o_dmem_we  <= 1'b0;
    end
  end

  // Result bundle: one valid pulse per instruction; reg_write and exc are zero otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_rd_addr    <= 5'd0;
      o_aluresult  <= 32'h0000_0000;
      o_write_data <= 32'h0000_0000;
      o_exc        <= 2'b00;
    end else begin
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
      o_exc       <= 2'b00;
      if (done || timeout) begin
        o_valid      <= 1'b1;
        o_mem_to_reg <= cap_mem_to_reg;
        o_reg_write  <= cap_reg_write & done;
        o_rd_addr    <= cap_rd;
        o_aluresult  <= cap_addr;
        o_write_data <= (done && !cap_we) ? load_extend(cap_funct3, cap_addr[1:0], i_dmem_rdata)
                                          : 32'h0000_0000;
        o_exc        <= done ? 2'b00 : 2'b10;
      end else if ((state == IDLE) && i_valid && !start) begin
        o_valid      <= 1'b1;
        o_mem_to_reg <= i_mem_to_reg;
        o_reg_write  <= i_reg_write & ~fault;
        o_rd_addr    <= i_rd_addr;
        o_aluresult  <= i_aluresult;
        o_write_data <= 32'h0000_0000;
        o_exc        <= fault ? (illegal ? 2'b11 : 2'b01) : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand-written corner
// sequences and randomized operations checked against a spec-level reference model.
module tb_mem_access;

  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_aluresult, i_store_data, i_dmem_rdata;
  logic [4:0]  i_rd_addr;
  logic        i_dmem_ack;
  logic        o_stall, o_dmem_req, o_dmem_we, o_valid, o_mem_to_reg, o_reg_write;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_aluresult, o_write_data;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_rd_addr;
  logic [1:0]  o_exc;

  int checks = 0;
  int errors = 0;

  mem_access #(.ACK_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
    .i_funct3(i_funct3), .i_aluresult(i_aluresult), .i_store_data(i_store_data),
    .i_rd_addr(i_rd_addr), .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_ack(i_dmem_ack), .o_valid(o_valid),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_rd_addr(o_rd_addr),
    .o_aluresult(o_aluresult), .o_write_data(o_write_data), .o_exc(o_exc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic rd, wr, m2r, rw;
    logic [2:0] f3;
    logic [31:0] alu, sdata, rdata;
    logic [4:0] rd_addr;
    int ack_k;   // REQ cycle in which ack arrives; 0 = never
  } op_t;

  typedef struct {
    logic [1:0] exc;
    logic rw, m2r, req, we;
    logic [31:0] wd, alu, addr, wdata;
    logic [4:0] rd_addr;
    logic [3:0] be;
    int stalls;
  } res_t;

  typedef struct { op_t op; res_t exp; } vec_t;

  function automatic op_t mk_op(input logic rd, wr, m2r, rw, input logic [2:0] f3,
                                input logic [31:0] alu, sdata, rdata,
                                input logic [4:0] rda, input int k);
    op_t o;
    o.rd = rd; o.wr = wr; o.m2r = m2r; o.rw = rw; o.f3 = f3; o.alu = alu;
    o.sdata = sdata; o.rdata = rdata; o.rd_addr = rda; o.ack_k = k;
    return o;
  endfunction

  function automatic res_t mk_res(input logic [1:0] exc, input logic rw, input logic [31:0] wd,
                                  input logic req, we, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wdata, input int st);
    res_t r;
    r = '{default: 0};
    r.exc = exc; r.rw = rw; r.wd = wd; r.req = req; r.we = we;
    r.addr = addr; r.be = be; r.wdata = wdata; r.stalls = st;
    return r;
  endfunction

  // Reference model derived from the access-size / alignment / timeout rules.
  function automatic res_t ref_model(input op_t op);
    res_t r;
    int bytes, off;
    bit legal;
    logic [31:0] mask, raw;
    r = '{default: 0};
    r.alu = op.alu; r.rd_addr = op.rd_addr; r.m2r = op.m2r;
    if (!op.rd && !op.wr) begin
      r.rw = op.rw;
      return r;
    end
    bytes = 1 << op.f3[1:0];
    off   = int'(op.alu[1:0]);
    legal = op.wr ? (op.f3 <= 3'd2) : (op.f3 <= 3'd5 && op.f3 != 3'd3);
    if (!legal) begin r.exc = 2'b11; return r; end
    if (off % bytes != 0) begin r.exc = 2'b01; return r; end
    r.req = 1'b1; r.we = op.wr; r.addr = op.alu & 32'hFFFF_FFFC;
    if (op.wr) begin
      r.be = 4'(((1 << bytes) - 1) << off);
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = op.sdata[8*(i % bytes) +: 8];
    end
    if (op.ack_k < 1 || op.ack_k > TO) begin
      r.exc = 2'b10; r.stalls = TO;
      return r;
    end
    r.stalls = op.ack_k; r.rw = op.rw;
    if (!op.wr) begin
      mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*bytes)) - 32'h1);
      raw  = (op.rdata >> (8*off)) & mask;
      if (!op.f3[2] && bytes < 4 && raw[8*bytes-1]) raw = raw | ~mask;
      r.wd = raw;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one instruction (holding it while stalled), answer the bus, collect the bundle.
  task automatic do_op(input op_t op, output res_t g, output bit got);
    int reqc;
    bit consumed, stall_now;
    g = '{default: 0};
    i_valid = 1'b1; i_mem_read = op.rd; i_mem_write = op.wr; i_mem_to_reg = op.m2r;
    i_reg_write = op.rw; i_funct3 = op.f3; i_aluresult = op.alu; i_store_data = op.sdata;
    i_rd_addr = op.rd_addr; i_dmem_ack = 1'b0;
    reqc = 0; consumed = 1'b0; got = 1'b0;
    for (int c = 0; c < TO + 8 && !got; c++) begin
      if (o_dmem_req) begin
        reqc++;
        if (!g.req) begin
          g.req = 1'b1; g.we = o_dmem_we; g.addr = o_dmem_addr;
          g.be = o_dmem_be; g.wdata = o_dmem_wdata;
        end
      end
      i_dmem_ack   = o_dmem_req && (reqc == op.ack_k);
      i_dmem_rdata = i_dmem_ack ? op.rdata : $urandom();
      #4;
      stall_now = o_stall;
      if (stall_now) g.stalls++;
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0;
      if (!consumed && !stall_now) begin
        consumed = 1'b1;
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
      end
      if (o_valid) begin
        got = 1'b1;
        g.exc = o_exc; g.rw = o_reg_write; g.m2r = o_mem_to_reg; g.wd = o_write_data;
        g.alu = o_aluresult; g.rd_addr = o_rd_addr;
      end
    end
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
  endtask

  task automatic apply(input string name, input op_t op, input res_t exp);
    res_t g;
    bit got;
    do_op(op, g, got);
    chk({name, "/valid"}, 32'(got), 32'd1);
    chk({name, "/exc"}, 32'(g.exc), 32'(exp.exc));
    chk({name, "/reg_write"}, 32'(g.rw), 32'(exp.rw));
    chk({name, "/write_data"}, g.wd, exp.wd);
    chk({name, "/aluresult"}, g.alu, op.alu);
    chk({name, "/rd_addr"}, 32'(g.rd_addr), 32'(op.rd_addr));
    chk({name, "/mem_to_reg"}, 32'(g.m2r), 32'(op.m2r));
    chk({name, "/stalls"}, 32'(g.stalls), 32'(exp.stalls));
    chk({name, "/req"}, 32'(g.req), 32'(exp.req));
    if (exp.req) begin
      chk({name, "/we"}, 32'(g.we), 32'(exp.we));
      chk({name, "/addr"}, g.addr, exp.addr);
      chk({name, "/be"}, 32'(g.be), 32'(exp.be));
      if (exp.we) chk({name, "/wdata"}, g.wdata, exp.wdata);
    end
    @(posedge i_clk); #1;
    chk({name, "/valid_pulse"}, 32'(o_valid), 32'd0);
    chk({name, "/idle_reg_write"}, 32'(o_reg_write), 32'd0);
    chk({name, "/idle_exc"}, 32'(o_exc), 32'd0);
    chk({name, "/idle_req"}, 32'(o_dmem_req), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    op_t  rop;
    int   kind;

    tbl[0]  = '{mk_op(0,0,0,1,3'b000,32'h0000_1234,32'h0,32'h0,5'd5,0),
                mk_res(2'b00,1,32'h0,0,0,32'h0,4'b0000,32'h0,0)};
    tbl[1]  = '{mk_op(1,0,1,1,3'b000,32'h0000_0103,32'h0,32'h80FF_FF7F,5'd7,3),
                mk_res(2'b00,1,32'hFFFF_FF80,1,0,32'h0000_0100,4'b0000,32'h0,3)};
    tbl[2]  = '{mk_op(1,0,1,1,3'b101,32'h0000_0202,32'h0,32'hBEEF_0000,5'd8,1),
                mk_res(2'b00,1,32'h0000_BEEF,1,0,32'h0000_0200,4'b0000,32'h0,1)};
    tbl[3]  = '{mk_op(0,1,0,0,3'b000,32'h0000_0301,32'h0000_00AB,32'h0,5'd0,2),
                mk_res(2'b00,0,32'h0,1,1,32'h0000_0300,4'b0010,32'hABAB_ABAB,2)};
    tbl[4]  = '{mk_op(1,0,1,1,3'b010,32'h0000_0402,32'h0,32'h0,5'd9,1),
                mk_res(2'b01,0,32'h0,0,0,32'h0,4'b0000,32'h0,0)};
    tbl[5]  = '{mk_op(1,0,1,1,3'b010,32'h0000_0500,32'h0,32'h0,5'd10,0),
                mk_res(2'b10,0,32'h0,1,0,32'h0000_0500,4'b0000,32'h0,4)};
    tbl[6]  = '{mk_op(0,1,0,0,3'b001,32'h0000_0502,32'h1234_CAFE,32'h0,5'd0,1),
                mk_res(2'b00,0,32'h0,1,1,32'h0000_0500,4'b1100,32'hCAFE_CAFE,1)};
    tbl[7]  = '{mk_op(1,0,1,1,3'b001,32'h0000_0006,32'h0,32'h8001_0000,5'd11,2),
                mk_res(2'b00,1,32'hFFFF_8001,1,0,32'h0000_0004,4'b0000,32'h0,2)};
    tbl[8]  = '{mk_op(0,1,0,0,3'b100,32'h0000_0700,32'h0000_0055,32'h0,5'd0,1),
                mk_res(2'b11,0,32'h0,0,0,32'h0,4'b0000,32'h0,0)};
    tbl[9]  = '{mk_op(1,0,1,1,3'b011,32'h0000_0800,32'h0,32'h0,5'd12,1),
                mk_res(2'b11,0,32'h0,0,0,32'h0,4'b0000,32'h0,0)};
    tbl[10] = '{mk_op(0,1,0,0,3'b010,32'h0000_0600,32'hDEAD_BEEF,32'h0,5'd0,4),
                mk_res(2'b00,0,32'h0,1,1,32'h0000_0600,4'b1111,32'hDEAD_BEEF,4)};
    tbl[11] = '{mk_op(1,0,1,1,3'b100,32'h0000_0001,32'h0,32'h0000_9C00,5'd13,1),
                mk_res(2'b00,1,32'h0000_009C,1,0,32'h0000_0000,4'b0000,32'h0,1)};

    // Reset state
    i_rst = 1'b1; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_to_reg = 1'b0;
    i_reg_write = 1'b0; i_funct3 = 3'b000; i_aluresult = 32'h0; i_store_data = 32'h0;
    i_rd_addr = 5'd0; i_dmem_rdata = 32'h0; i_dmem_ack = 1'b0;
    #12;
    chk("rst/stall", 32'(o_stall), 32'd0);
    chk("rst/valid", 32'(o_valid), 32'd0);
    chk("rst/req", 32'(o_dmem_req), 32'd0);
    chk("rst/we", 32'(o_dmem_we), 32'd0);
    chk("rst/addr", o_dmem_addr, 32'd0);
    chk("rst/wdata", o_dmem_wdata, 32'd0);
    chk("rst/be", 32'(o_dmem_be), 32'd0);
    chk("rst/bundle", {o_aluresult ^ o_write_data}, 32'd0);
    chk("rst/ctrl", {22'd0, o_mem_to_reg, o_reg_write, o_rd_addr, o_exc}, 32'd0);
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].exp);

    // Ack arriving while idle must be ignored
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h1234_5678;
    #4;
    chk("late_ack/stall", 32'(o_stall), 32'd0);
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b0;
    chk("late_ack/valid", 32'(o_valid), 32'd0);
    chk("late_ack/req", 32'(o_dmem_req), 32'd0);

    // Reset asserted while a request is outstanding
    i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_aluresult = 32'h0000_0900;
    i_reg_write = 1'b1; i_rd_addr = 5'd3;
    @(posedge i_clk); #1;
    chk("rst_req/req_before", 32'(o_dmem_req), 32'd1);
    #2;
    i_valid = 1'b0; i_mem_read = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("rst_req/req", 32'(o_dmem_req), 32'd0);
    chk("rst_req/stall", 32'(o_stall), 32'd0);
    chk("rst_req/valid", 32'(o_valid), 32'd0);
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
    apply("rst_req/alu_after", mk_op(0,0,1,1,3'b000,32'hCAFE_0001,32'h0,32'h0,5'd21,0),
          mk_res(2'b00,1,32'h0,0,0,32'h0,4'b0000,32'h0,0));

    // Randomized operations against the reference model
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      rop.rd = (kind == 1); rop.wr = (kind == 2); rop.m2r = (kind == 1);
      rop.rw = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      rop.f3 = 3'($urandom_range(0, 7));
      rop.alu = $urandom(); rop.sdata = $urandom(); rop.rdata = $urandom();
      rop.rd_addr = 5'($urandom_range(0, 31));
      rop.ack_k = $urandom_range(0, TO + 1);
      apply($sformatf("rand%0d", n), rop, ref_model(rop));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
